periph_bus_ctrl: RTL and testbench

//  Address decoder and access sequencer for the CPU data bus. Turns one CPU load/store into

---
 rtl/periph_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_periph_bus_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/periph_bus_ctrl.sv
// rtl/periph_bus_ctrl.sv - CPU data-bus address decoder and wait-state sequencer
// Optional sticky error capture is enabled by defining PBC_ERR_CAPTURE_EN.
module periph_bus_ctrl #(
  parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
  parameter logic [31:0] DMEM_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] TBMAN_BASE = 32'h8000_0000,
  parameter logic [31:0] TBMAN_MASK = 32'hFFFF_F000,
  parameter logic [31:0] GPIO_BASE  = 32'h8000_1000,
  parameter logic [31:0] GPIO_MASK  = 32'hFFFF_F000,
  parameter int unsigned DMEM_WS    = 0,
  parameter int unsigned TBMAN_WS   = 1,
  parameter int unsigned GPIO_WS    = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  output logic        stall,
  output logic        bus_we,
  output logic        cs_dmem_n,
  output logic        cs_tbman_n,
  output logic        cs_gpio_n,
  output logic        bus_err,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [31:0] err_addr
);

  if (DMEM_WS > 15) begin : g_dmem_ws_bad
    $error("DMEM_WS must be 0..15");
  end
  if (TBMAN_WS > 15) begin : g_tbman_ws_bad
    $error("TBMAN_WS must be 0..15");
  end
  if (GPIO_WS > 15) begin : g_gpio_ws_bad
    $error("GPIO_WS must be 0..15");
  end

  localparam logic [3:0] DMEM_WS4  = 4'(DMEM_WS);
  localparam logic [3:0] TBMAN_WS4 = 4'(TBMAN_WS);
  localparam logic [3:0] GPIO_WS4  = 4'(GPIO_WS);

  typedef enum logic [1:0] {R_NONE, R_DMEM, R_TBMAN, R_GPIO} region_t;
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state;
  logic [3:0] cnt;
  region_t    lat_region;
  logic       lat_we;

  region_t    dec_region;
  logic [3:0] dec_ws;
  region_t    act_region;

  // Overlapping regions resolve DMEM first, then TBMAN, then GPIO.
  always_comb begin
    dec_region = R_NONE;
    dec_ws     = 4'd0;
    if ((addr & DMEM_MASK) == DMEM_BASE) begin
      dec_region = R_DMEM;
      dec_ws     = DMEM_WS4;
    end else if ((addr & TBMAN_MASK) == TBMAN_BASE) begin
      dec_region = R_TBMAN;
      dec_ws     = TBMAN_WS4;
    end else if ((addr & GPIO_MASK) == GPIO_BASE) begin
      dec_region = R_GPIO;
      dec_ws     = GPIO_WS4;
    end
  end

  // The first cycle of an access is driven straight from the decode so zero-wait
  // regions complete in the cycle the CPU presents them; reset forces everything idle.
  always_comb begin
    act_region = R_NONE;
    stall      = 1'b0;
    bus_we     = 1'b0;
    bus_err    = 1'b0;
    if (n_rst) begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (dec_region != R_NONE) begin
              act_region = dec_region;
              if (dec_ws == 4'd0) bus_we = we;
              else                stall  = 1'b1;
            end else begin
              bus_err = 1'b1;
            end
          end
        end
        S_WAIT: begin
          act_region = lat_region;
          if (cnt > 4'd1) stall  = 1'b1;
          else            bus_we = lat_we;
        end
        default: act_region = R_NONE;
      endcase
    end
  end

  assign cs_dmem_n  = (act_region != R_DMEM);
  assign cs_tbman_n = (act_region != R_TBMAN);
  assign cs_gpio_n  = (act_region != R_GPIO);

  // req and addr are deliberately ignored once in WAIT: the access always runs out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      lat_region <= R_NONE;
      lat_we     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && (dec_region != R_NONE) && (dec_ws != 4'd0)) begin
            state      <= S_WAIT;
            cnt        <= dec_ws;
            lat_region <= dec_region;
            lat_we     <= we;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PBC_ERR_CAPTURE_EN
  // Only the first unmapped address is kept; a clear beats a same-cycle error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_flag <= 1'b0;
      err_addr <= 32'd0;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_addr <= 32'd0;
    end else if (bus_err && !err_flag) begin
      err_flag <= 1'b1;
      err_addr <= addr;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_flag       = 1'b0;
  assign err_addr       = 32'd0;
`endif

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb/tb_periph_bus_ctrl.sv - directed vector bench for periph_bus_ctrl
// Error-capture expectations follow PBC_ERR_CAPTURE_EN.
module tb_periph_bus_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic        stall;
  logic        bus_we;
  logic        cs_dmem_n;
  logic        cs_tbman_n;
  logic        cs_gpio_n;
  logic        bus_err;
  logic        err_clr;
  logic        err_flag;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

`ifdef PBC_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  periph_bus_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .stall      (stall),
    .bus_we     (bus_we),
    .cs_dmem_n  (cs_dmem_n),
    .cs_tbman_n (cs_tbman_n),
    .cs_gpio_n  (cs_gpio_n),
    .bus_err    (bus_err),
    .err_clr    (err_clr),
    .err_flag   (err_flag),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  // {cs_dmem_n, cs_tbman_n, cs_gpio_n, stall, bus_we, bus_err}
  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [5:0] obs();
    return {cs_dmem_n, cs_tbman_n, cs_gpio_n, stall, bus_we, bus_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a);
    req  = r;
    we   = w;
    addr = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic r, input logic w, input logic [31:0] a,
                     input logic [5:0] exp);
    drive(r, w, a);
    #3;
    chk(name, 32'(obs()), 32'(exp));
    next_cycle();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 6'b111_000};
    vecs[1]  = '{1'b1, 1'b1, 32'h1000_0010, 6'b011_010};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 6'b111_000};
    vecs[3]  = '{1'b1, 1'b0, 32'h8000_1004, 6'b110_100};
    vecs[4]  = '{1'b1, 1'b0, 32'h8000_1004, 6'b110_100};
    vecs[5]  = '{1'b1, 1'b0, 32'h8000_1004, 6'b110_000};
    vecs[6]  = '{1'b1, 1'b1, 32'h8000_0000, 6'b101_100};
    vecs[7]  = '{1'b1, 1'b1, 32'h8000_0000, 6'b101_010};
    vecs[8]  = '{1'b1, 1'b0, 32'h1000_0000, 6'b011_000};
    vecs[9]  = '{1'b1, 1'b0, 32'h4000_0000, 6'b111_001};
    vecs[10] = '{1'b0, 1'b0, 32'h4000_0000, 6'b111_000};
    vecs[11] = '{1'b1, 1'b1, 32'h8000_1FFC, 6'b110_100};
    vecs[12] = '{1'b1, 1'b1, 32'h8000_1FFC, 6'b110_100};
    vecs[13] = '{1'b1, 1'b1, 32'h8000_1FFC, 6'b110_010};
    vecs[14] = '{1'b1, 1'b1, 32'h8000_2000, 6'b111_001};
    vecs[15] = '{1'b1, 1'b0, 32'h1000_FFFF, 6'b011_000};
    vecs[16] = '{1'b1, 1'b0, 32'h1001_0000, 6'b111_001};

    n_rst   = 1'b0;
    err_clr = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #3;
    chk("reset_outputs", 32'(obs()), 32'(6'b111_000));
    chk("reset_err_flag", 32'(err_flag), 32'd0);
    chk("reset_err_addr", err_addr, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].exp);
    end

    // First captured error came from vec9; later errors must not overwrite it.
    chk("cap_flag_after_table", 32'(err_flag), 32'(CAP));
    chk("cap_addr_after_table", err_addr, CAP ? 32'h4000_0000 : 32'h0);
    cyc("second_err", 1'b1, 1'b0, 32'h5000_0000, 6'b111_001);
    chk("cap_addr_kept", err_addr, CAP ? 32'h4000_0000 : 32'h0);

    // Reset in the middle of a GPIO wait.
    drive(1'b1, 1'b1, 32'h8000_1000);
    #3;
    chk("rst_pre_wait", 32'(obs()), 32'(6'b110_100));
    next_cycle();
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_mid_wait", 32'(obs()), 32'(6'b111_000));
    chk("rst_clears_flag", 32'(err_flag), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0);
    #2;
    n_rst = 1'b1;
    #1;
    chk("rst_idle_after", 32'(obs()), 32'(6'b111_000));
    next_cycle();
    cyc("rst_then_dmem_store", 1'b1, 1'b1, 32'h1000_0020, 6'b011_010);

    // Clear behaviour, including clear colliding with a new error.
    cyc("err_again", 1'b1, 1'b0, 32'h6000_0000, 6'b111_001);
    chk("cap_addr_new", err_addr, CAP ? 32'h6000_0000 : 32'h0);
    err_clr = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    next_cycle();
    chk("clr_flag", 32'(err_flag), 32'd0);
    chk("clr_addr", err_addr, 32'd0);
    cyc("clr_vs_err", 1'b1, 1'b0, 32'h7000_0000, 6'b111_001);
    err_clr = 1'b0;
    chk("clr_wins_flag", 32'(err_flag), 32'd0);
    chk("clr_wins_addr", err_addr, 32'd0);

    // Dropping req inside a GPIO wait still completes all three select cycles.
    cyc("drop_c0", 1'b1, 1'b0, 32'h8000_1008, 6'b110_100);
    cyc("drop_c1", 1'b0, 1'b0, 32'h1000_0000, 6'b110_100);
    cyc("drop_c2", 1'b0, 1'b0, 32'h1000_0000, 6'b110_000);
    cyc("drop_c3", 1'b0, 1'b0, 32'h1000_0000, 6'b111_000);

    // Overlap priority: an address in TBMAN and DMEM masks would still hit DMEM first;
    // with default maps, check TBMAN top edge and GPIO bottom edge directly.
    cyc("tbman_top", 1'b1, 1'b0, 32'h8000_0FFF, 6'b101_100);
    cyc("tbman_top_fin", 1'b1, 1'b0, 32'h8000_0FFF, 6'b101_000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
